pipe_addsub: RTL and testbench
==============================

# pipe_addsub

Parametrised, pipelined adder/subtractor that succeeds the fixed 32-bit ripple-carry adder in the arithmetic datapath. Operands are split into SEG-bit segments. One segment is summed per pipeline stage, and the carry is registered between stages. This trades latency for a short critical path of one SEG-bit ripple. A valid/ready handshake with whole-pipeline stall lets the block sit between producer and consumer stages without external flow control.

## Interface
- WIDTH, 32, operand and result width in bits; must be a multiple of SEG.
- SEG, 8, segment width per pipeline stage; number of stages NSTG = WIDTH/SEG (≥1).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  block accepts operand set this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in; used only when sub=0.
- sub  in  1  0: s=a+b+ci; 1: s=a−b (ci ignored).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- s  out  WIDTH  sum/difference.
- co  out  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.

## Operation
- Effective operands: B' = sub ? ~b : b; C0 = sub ? 1 : ci.
- Stage k (k=0..NSTG−1) computes segment k: {c,sum} = A[k] + B'[k] + carry from stage k−1, where stage 0 uses C0. The segment sum and carry are registered.
- Unprocessed upper operand segments travel down the pipeline with the data. Completed lower sum segments also travel, so each stage holds exactly one transaction.
- Each stage has a valid bit. Pipeline advance enable: en = out_ready | ~out_valid.
- in_ready = en (combinational from out_ready and out_valid).
- Accept: in_valid & in_ready. When en=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- When en=0, all stage registers, including valid bits, hold.
- co = carry out of the final stage.
- ovf = (A[W−1] == B'[W−1]) & (s[W−1] != A[W−1]), evaluated in the last stage from the carried sign bits.
- s, co and ovf are driven from last-stage registers. When out_valid=0 their values are don't-care but stable.
- Reset, whether asserted idle or mid-operation, clears every valid bit and every data register to 0 immediately. In-flight transactions are discarded; there is no partial output.

## Timing
- Reset values: out_valid=0, s=0, co=0, ovf=0. in_ready=1 after reset, since out_valid=0.
- Latency: a transaction accepted at edge t appears with out_valid=1 after edge t+NSTG−1, i.e. NSTG cycles from the accept cycle to the result cycle.
- Throughput: 1 transaction/cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, s/co/ovf/out_valid hold, in_ready=0, and no stage moves.
- Simultaneous accept and retire in the same cycle is allowed and loses no data.
- Bubbles are not compressed except at the output stage: in_ready=1 whenever out_valid=0.
- NSTG=1 (SEG=WIDTH) degenerates to a single registered adder with 1-cycle latency.
- Reset deassertion: the first accept may occur on the first clock edge after reset falls.

## Test plan
- Reset/basic, WIDTH=32, SEG=8: after reset, check out_valid=0, s=0, in_ready=1. Drive a=0x0000_0001, b=0x0000_0002, ci=1, sub=0 → 4 cycles later s=0x0000_0004, co=0, ovf=0.
- Full carry ripple across all segments: a=0xFFFF_FFFF, b=0x0000_0000, ci=1 → s=0x0000_0000, co=1, ovf=0. Then a=0x7FFF_FFFF, b=1, ci=0 → s=0x8000_0000, ovf=1, co=0.
- Subtract: a=5, b=7, sub=1, ci=1 (ignored) → s=0xFFFF_FFFE, co=0. Then a=0x8000_0000, b=1, sub=1 → s=0x7FFF_FFFF, ovf=1, co=1.
- Back-to-back streaming: 100 random transactions with in_valid=1 and out_ready=1 → results arrive in order, one per cycle, each matching a reference model.
- Backpressure: random in_valid and random out_ready (50%). Check that s/co/ovf hold while out_valid=1 and out_ready=0, that there is no loss or duplication, and that in_ready equals out_ready|~out_valid every cycle.
- Reset mid-operation with 3 transactions in flight: assert reset asynchronously (not on an edge) → out_valid=0 and s=0 immediately. None of the 3 results ever appears. Run with WIDTH=16, SEG=4 and with WIDTH=8, SEG=8.

Source files
------------

// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: one SEG-bit segment per stage, carry registered between stages.
// Valid/ready handshake with a whole-pipeline stall driven by the output stage.
module pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NSTG = WIDTH / SEG;

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             ovf_q;

  // The whole pipeline moves only when the output slot is free or being retired.
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub ? 1'b1 : ci;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic                  v_q;
    logic                  c_q;
    logic [(k+1)*SEG-1:0]  sum_q;
    logic                  prev_v;
    logic                  cin;
    logic [SEG-1:0]        opa;
    logic [SEG-1:0]        opb;
    logic [SEG:0]          seg_sum;
    logic [(k+1)*SEG-1:0]  nxt_sum;

    if (k == 0) begin : g_src
      assign prev_v  = in_valid;
      assign cin     = c0;
      assign opa     = a[SEG-1:0];
      assign opb     = b_eff[SEG-1:0];
      assign nxt_sum = seg_sum[SEG-1:0];
    end else begin : g_src
      assign prev_v  = g_stg[k-1].v_q;
      assign cin     = g_stg[k-1].c_q;
      assign opa     = g_stg[k-1].g_ops.a_q[(k+1)*SEG-1:k*SEG];
      assign opb     = g_stg[k-1].g_ops.b_q[(k+1)*SEG-1:k*SEG];
      assign nxt_sum = {seg_sum[SEG-1:0], g_stg[k-1].sum_q};
    end

    assign seg_sum = {1'b0, opa} + {1'b0, opb} + {{SEG{1'b0}}, cin};

    // Data registers only load on a real transaction so outputs stay put while bubbles pass.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (en) begin
        v_q <= prev_v;
        if (prev_v) begin
          c_q   <= seg_sum[SEG];
          sum_q <= nxt_sum;
        end
      end
    end

    // Operand segments not yet summed ride along with the transaction.
    if (k < NSTG - 1) begin : g_ops
      logic [WIDTH-1:(k+1)*SEG] a_q;
      logic [WIDTH-1:(k+1)*SEG] b_q;
      logic [WIDTH-1:(k+1)*SEG] nxt_a;
      logic [WIDTH-1:(k+1)*SEG] nxt_b;

      if (k == 0) begin : g_in
        assign nxt_a = a[WIDTH-1:SEG];
        assign nxt_b = b_eff[WIDTH-1:SEG];
      end else begin : g_in
        assign nxt_a = g_stg[k-1].g_ops.a_q[WIDTH-1:(k+1)*SEG];
        assign nxt_b = g_stg[k-1].g_ops.b_q[WIDTH-1:(k+1)*SEG];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en && prev_v) begin
          a_q <= nxt_a;
          b_q <= nxt_b;
        end
      end
    end

    if (k == NSTG - 1) begin : g_last
      // Top segment holds the sign bits of A and B', so signed overflow is decided here.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ovf_q <= 1'b0;
        end else if (en && prev_v) begin
          ovf_q <= (opa[SEG-1] == opb[SEG-1]) & (seg_sum[SEG-1] != opa[SEG-1]);
        end
      end
    end
  end

  assign out_valid = g_stg[NSTG-1].v_q;
  assign s         = g_stg[NSTG-1].sum_q;
  assign co        = g_stg[NSTG-1].c_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: 32/8 instance checked against a cycle-level behavioural model,
// plus 16/4 and 8/8 instances exercised with directed vectors and mid-cycle reset.
module tb_pipe_addsub;

  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;

  logic          in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf;
  logic [W-1:0]  a, b, s;

  logic          in_valid2, in_ready2, ci2, sub2, out_valid2, out_ready2, co2, ovf2;
  logic [15:0]   a2, b2, s2;

  logic          in_valid3, in_ready3, ci3, sub3, out_valid3, out_ready3, co3, ovf3;
  logic [7:0]    a3, b3, s3;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_ret = 0;

  typedef struct {
    logic         v;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } slot_t;

  slot_t mp [N];

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .ovf(ovf)
  );

  pipe_addsub #(.WIDTH(16), .SEG(4)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .ci(ci2), .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2),
    .s(s2), .co(co2), .ovf(ovf2)
  );

  pipe_addsub #(.WIDTH(8), .SEG(8)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
    .a(a3), .b(b3), .ci(ci3), .sub(sub3), .out_valid(out_valid3), .out_ready(out_ready3),
    .s(s3), .co(co3), .ovf(ovf3)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: unsigned result/carry and signed range check on wide integers.
  function automatic slot_t refResult(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                      input logic tci, input logic tsub);
    slot_t           r;
    longint unsigned full;
    longint          sa, sb, sres;
    sa = longint'($signed(ta));
    sb = longint'($signed(tb));
    r.v = 1'b1;
    if (!tsub) begin
      full = longint'(ta) + longint'(tb) + longint'(tci);
      r.s  = full[W-1:0];
      r.co = full[W];
      sres = sa + sb + longint'(tci);
    end else begin
      r.s  = ta - tb;
      r.co = (ta >= tb);
      sres = sa - sb;
    end
    r.ovf = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    return r;
  endfunction

  // Compare process: model of the pipeline occupancy, checked every cycle away from the edge.
  always @(negedge clk) begin
    logic mdl_en;
    if (reset) begin
      for (int i = 0; i < N; i++) mp[i] = '{v: 1'b0, s: '0, co: 1'b0, ovf: 1'b0};
    end else begin
      mdl_en = out_ready | ~mp[N-1].v;
      checkOutput("in_ready", in_ready, mdl_en);
      checkOutput("out_valid", out_valid, mp[N-1].v);
      if (mp[N-1].v) begin
        checkOutput("model_s", s, mp[N-1].s);
        checkOutput("model_co", co, mp[N-1].co);
        checkOutput("model_ovf", ovf, mp[N-1].ovf);
      end
      if (in_valid && in_ready) n_acc++;
      if (out_valid && out_ready) n_ret++;
      if (mdl_en) begin
        for (int i = N - 1; i > 0; i--) mp[i] = mp[i-1];
        if (in_valid) mp[0] = refResult(a, b, ci, sub);
        else          mp[0] = '{v: 1'b0, s: '0, co: 1'b0, ovf: 1'b0};
      end
    end
  end

  // Drives one operand set just after an edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tci, input logic tsub);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    ci        = tci;
    sub       = tsub;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic waitResult(input string name, input logic [W-1:0] es, input logic eco,
                            input logic eovf);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_latency"}, n, N - 1);
    checkOutput({name, "_s"}, s, es);
    checkOutput({name, "_co"}, co, eco);
    checkOutput({name, "_ovf"}, ovf, eovf);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ret0;
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b0;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0; sub2 = 1'b0; out_ready2 = 1'b1;
    in_valid3 = 1'b0; a3 = '0; b3 = '0; ci3 = 1'b0; sub3 = 1'b0; out_ready3 = 1'b1;

    #3;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_s", s, 32'h0);
    checkOutput("rst_co", co, 1'b0);
    checkOutput("rst_ovf", ovf, 1'b0);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_out_valid2", out_valid2, 1'b0);
    checkOutput("rst_out_valid3", out_valid3, 1'b0);

    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    $display("[TB] reset released, directed vectors");
    applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0);
    waitResult("add_basic", 32'h0000_0004, 1'b0, 1'b0);

    @(posedge clk); #1 applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    waitResult("full_ripple", 32'h0000_0000, 1'b1, 1'b0);
    @(posedge clk); #1 applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    waitResult("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
    @(posedge clk); #1 applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    waitResult("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0);
    @(posedge clk); #1 applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    waitResult("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);

    $display("[TB] streaming 100 transactions");
    @(posedge clk); #1;
    ret0 = n_ret;
    for (int i = 0; i < 100; i++) begin
      in_valid  = 1'b1;
      a         = $urandom;
      b         = $urandom;
      ci        = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 checkOutput("stream_count", n_ret - ret0, 100);

    $display("[TB] random backpressure");
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      a         = $urandom;
      b         = $urandom;
      ci        = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 checkOutput("accept_vs_retire", n_ret, n_acc);

    $display("[TB] 16/4 instance: directed add and mid-cycle reset");
    in_valid2 = 1'b1; a2 = 16'h1234; b2 = 16'h0FFF; ci2 = 1'b1; sub2 = 1'b0;
    @(posedge clk); #1 in_valid2 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("w16_latency", n, 3);
    checkOutput("w16_s", s2, 16'h2234);
    checkOutput("w16_co", co2, 1'b0);
    checkOutput("w16_ovf", ovf2, 1'b0);

    @(posedge clk); #1 in_valid2 = 1'b1; a2 = 16'h0101; b2 = 16'h0202;
    @(posedge clk); #1 a2 = 16'h7FFF; b2 = 16'h0001;
    @(posedge clk); #1 a2 = 16'hFFFF; b2 = 16'hFFFF;
    @(posedge clk); #1 in_valid2 = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("w16_rst_valid", out_valid2, 1'b0);
    checkOutput("w16_rst_s", s2, 16'h0);
    checkOutput("w16_rst_co", co2, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("w16_no_ghost", out_valid2, 1'b0);
    end
    @(posedge clk); #1 in_valid2 = 1'b1; a2 = 16'h8000; b2 = 16'h0001; ci2 = 1'b0; sub2 = 1'b1;
    @(posedge clk); #1 in_valid2 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("w16_sub_latency", n, 3);
    checkOutput("w16_sub_s", s2, 16'h7FFF);
    checkOutput("w16_sub_co", co2, 1'b1);
    checkOutput("w16_sub_ovf", ovf2, 1'b1);

    $display("[TB] 8/8 instance: stall, mid-cycle reset, subtract");
    @(posedge clk); #1;
    in_valid3 = 1'b1; a3 = 8'h7F; b3 = 8'h01; ci3 = 1'b0; sub3 = 1'b0; out_ready3 = 1'b0;
    @(posedge clk); #1 in_valid3 = 1'b0;
    @(negedge clk);
    checkOutput("w8_valid", out_valid3, 1'b1);
    checkOutput("w8_s", s3, 8'h80);
    checkOutput("w8_co", co3, 1'b0);
    checkOutput("w8_ovf", ovf3, 1'b1);
    checkOutput("w8_stall_ready", in_ready3, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("w8_hold_valid", out_valid3, 1'b1);
    checkOutput("w8_hold_s", s3, 8'h80);
    #2 reset = 1'b1;
    #1;
    checkOutput("w8_rst_valid", out_valid3, 1'b0);
    checkOutput("w8_rst_s", s3, 8'h00);
    checkOutput("w8_rst_ovf", ovf3, 1'b0);
    checkOutput("w8_rst_ready", in_ready3, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("w8_no_ghost", out_valid3, 1'b0);
    end
    @(posedge clk); #1;
    in_valid3 = 1'b1; a3 = 8'h05; b3 = 8'h07; ci3 = 1'b1; sub3 = 1'b1; out_ready3 = 1'b1;
    @(posedge clk); #1 in_valid3 = 1'b0;
    @(negedge clk);
    checkOutput("w8_sub_valid", out_valid3, 1'b1);
    checkOutput("w8_sub_s", s3, 8'hFE);
    checkOutput("w8_sub_co", co3, 1'b0);
    checkOutput("w8_sub_ovf", ovf3, 1'b0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
